// File: rtl/ct_spsram_req_ctrl.sv
// Request-side controller for one ct_spsram_* single-port SRAM: valid/ready requests in, in-order read data out.
// Define CT_SPSRAM_INIT_EN to zero-fill the whole SRAM after reset before accepting requests.
module ct_spsram_req_ctrl #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 128,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_wmask,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_busy,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  localparam int PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W  = $clog2(RSP_DEPTH + 1);
  localparam int LAST_I = RSP_DEPTH - 1;
  localparam logic [PTR_W-1:0] LAST_PTR  = LAST_I[PTR_W-1:0];
  localparam logic [CNT_W-1:0] FULL_CNT  = RSP_DEPTH[CNT_W-1:0];
  localparam logic [CNT_W:0]   DEPTH_EXT = RSP_DEPTH[CNT_W:0];

  logic                  in_idle;
  logic                  req_acc;
  logic                  rd_acc;
  logic                  wr_act;
  logic                  rd_pend_reg;
  logic                  push;
  logic                  pop;
  logic [CNT_W:0]        credit_used;
  logic                  has_credit;
  logic [CNT_W-1:0]      fifo_cnt_reg;
  logic [CNT_W-1:0]      fifo_cnt_next;
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      wr_ptr_next;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_next;
  logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];

`ifdef CT_SPSRAM_INIT_EN
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  state_t                state_reg;
  logic                  init_busy_reg;
  logic [ADDR_WIDTH-1:0] init_addr_reg;
  logic                  sweep_act;

  // One zero-write per cycle; leave INIT once the address counter wraps.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_reg     <= ST_INIT;
      init_busy_reg <= 1'b1;
      init_addr_reg <= '0;
    end else begin
      case (state_reg)
        ST_INIT: begin
          init_addr_reg <= init_addr_reg + ADDR_WIDTH'(1);
          if (init_addr_reg == '1) begin
            state_reg     <= ST_IDLE;
            init_busy_reg <= 1'b0;
          end
        end
        default: begin
          state_reg     <= ST_IDLE;
          init_busy_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_idle   = (state_reg == ST_IDLE);
  assign sweep_act = init_busy_reg & cpurst_b;
  assign init_busy = init_busy_reg;
`else
  assign in_idle   = 1'b1;
  assign init_busy = 1'b0;
`endif

  // Credit counts the read still in flight to the FIFO; a same-cycle pop is not credited.
  assign credit_used = {1'b0, fifo_cnt_reg} + {{CNT_W{1'b0}}, rd_pend_reg};
  assign has_credit  = (credit_used < DEPTH_EXT);

  assign req_rdy = cpurst_b & in_idle & (req_wr | has_credit);
  assign req_acc = req_vld & req_rdy;
  assign rd_acc  = req_acc & ~req_wr;
  assign wr_act  = req_acc & req_wr & (|req_wmask);

  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = '0;
    sram_d    = '0;
`ifdef CT_SPSRAM_INIT_EN
    if (sweep_act) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_a    = init_addr_reg;
    end else
`endif
    if (rd_acc) begin
      sram_cen = 1'b0;
      sram_a   = req_addr;
    end else if (wr_act) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = ~req_wmask;
      sram_a    = req_addr;
      sram_d    = req_wdata;
    end
  end

  assign push    = rd_pend_reg;
  assign rsp_vld = (fifo_cnt_reg != '0);
  assign pop     = rsp_vld & rsp_rdy;

  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    fifo_cnt_next = fifo_cnt_reg;
    if (push) begin
      wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   fifo_cnt_next = fifo_cnt_reg + CNT_W'(1);
      2'b01:   fifo_cnt_next = fifo_cnt_reg - CNT_W'(1);
      default: fifo_cnt_next = fifo_cnt_reg;
    endcase
  end

  // Reset drops any read in flight: rd_pend clears, so its Q is never captured.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rd_pend_reg  <= 1'b0;
      fifo_cnt_reg <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
    end else begin
      rd_pend_reg  <= rd_acc;
      fifo_cnt_reg <= fifo_cnt_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= sram_q;
    end
  end

  assign rsp_rdata = fifo_mem[rd_ptr_reg];

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst_b && push && !pop) begin
      assert (fifo_cnt_reg != FULL_CNT);
    end
  end

endmodule

// File: tb/tb_ct_spsram_req_ctrl.sv
// Directed bench for ct_spsram_req_ctrl with a behavioural single-port SRAM; covers CT_SPSRAM_INIT_EN when defined.
module tb_ct_spsram_req_ctrl;

`ifdef CT_SPSRAM_INIT_EN
  localparam int AW = 4;
  localparam logic [AW-1:0] A1 = 4'h1;
  localparam logic [AW-1:0] A2 = 4'h2;
  localparam logic [AW-1:0] A3 = 4'h3;
`else
  localparam int AW = 8;
  localparam logic [AW-1:0] A1 = 8'h10;
  localparam logic [AW-1:0] A2 = 8'h20;
  localparam logic [AW-1:0] A3 = 8'h30;
`endif
  localparam int DW    = 128;
  localparam int DEPTH = 2;
  localparam int WORDS = 1 << AW;

  logic          clk = 1'b0;
  logic          cpurst_b;
  logic          req_vld;
  logic          req_rdy;
  logic          req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [DW-1:0] req_wmask;
  logic          rsp_vld;
  logic          rsp_rdy;
  logic [DW-1:0] rsp_rdata;
  logic          init_busy;
  logic [AW-1:0] sram_a;
  logic          sram_cen;
  logic          sram_gwen;
  logic [DW-1:0] sram_wen;
  logic [DW-1:0] sram_d;
  logic [DW-1:0] sram_q;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] mem     [WORDS];
  logic [DW-1:0] exp_mem [WORDS];
  logic          preload;
  logic [DW-1:0] exp_q [$];

  ct_spsram_req_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RSP_DEPTH  (DEPTH)
  ) dut (
    .forever_cpuclk (clk),
    .cpurst_b       (cpurst_b),
    .req_vld        (req_vld),
    .req_rdy        (req_rdy),
    .req_wr         (req_wr),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_wmask      (req_wmask),
    .rsp_vld        (rsp_vld),
    .rsp_rdy        (rsp_rdy),
    .rsp_rdata      (rsp_rdata),
    .init_busy      (init_busy),
    .sram_a         (sram_a),
    .sram_cen       (sram_cen),
    .sram_gwen      (sram_gwen),
    .sram_wen       (sram_wen),
    .sram_d         (sram_d),
    .sram_q         (sram_q)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: per-bit active-low write enable, Q updated only by reads.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= '1;
    end else if (!sram_cen) begin
      if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else            sram_q      <= mem[sram_a];
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_cen"},  sram_cen,  1);
    chk({tag, "_gwen"}, sram_gwen, 1);
    chk({tag, "_wen"},  sram_wen,  {DW{1'b1}});
    chk({tag, "_a"},    sram_a,    0);
    chk({tag, "_d"},    sram_d,    0);
  endtask

  task automatic op_wr(input string tag, input logic [AW-1:0] addr,
                       input logic [DW-1:0] data, input logic [DW-1:0] mask);
    tick();
    req_vld = 1'b1; req_wr = 1'b1; req_addr = addr; req_wdata = data; req_wmask = mask;
    #1;
    chk({tag, "_rdy"}, req_rdy, 1);
    if (mask != '0) begin
      chk({tag, "_cen"},  sram_cen,  0);
      chk({tag, "_gwen"}, sram_gwen, 0);
      chk({tag, "_wen"},  sram_wen,  ~mask);
      chk({tag, "_d"},    sram_d,    data);
      chk({tag, "_a"},    sram_a,    addr);
    end else begin
      chk({tag, "_nop_cen"}, sram_cen, 1);
    end
    exp_mem[addr] = (exp_mem[addr] & ~mask) | (data & mask);
  endtask

  task automatic op_rd(input string tag, input logic [AW-1:0] addr);
    tick();
    req_vld = 1'b1; req_wr = 1'b0; req_addr = addr;
    #1;
    chk({tag, "_rdy"},  req_rdy,   1);
    chk({tag, "_cen"},  sram_cen,  0);
    chk({tag, "_gwen"}, sram_gwen, 1);
    chk({tag, "_wen"},  sram_wen,  {DW{1'b1}});
    chk({tag, "_a"},    sram_a,    addr);
  endtask

  initial begin
    int busy_cnt;
    int pops;
    int accepts;
    logic [AW-1:0] a4;

    cpurst_b = 1'b0; preload = 1'b1; rsp_rdy = 1'b1;
    req_vld = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
`ifdef CT_SPSRAM_INIT_EN
    for (int i = 0; i < WORDS; i++) exp_mem[i] = '0;
`else
    for (int i = 0; i < WORDS; i++) exp_mem[i] = '1;
`endif
    tick();
    tick();
    // Reset: nothing accepted even with a valid write offered.
    req_vld = 1'b1; req_wr = 1'b1; req_wmask = '1; req_wdata = '1;
    #1;
    chk("rst_rdy", req_rdy, 0);
    chk("rst_vld", rsp_vld, 0);
    chk("rst_cen", sram_cen, 1);
`ifdef CT_SPSRAM_INIT_EN
    chk("rst_init_busy", init_busy, 1);
`else
    chk("rst_init_busy", init_busy, 0);
`endif
    req_vld = 1'b0;
    preload = 1'b0;
    tick();
    cpurst_b = 1'b1;
    #1;

`ifdef CT_SPSRAM_INIT_EN
    // Test 6: 16-cycle zero sweep, addresses 0..15 in order.
    busy_cnt = 0;
    for (int k = 0; k < 40 && init_busy; k++) begin
      chk("t6_sweep_a",    sram_a,    k);
      chk("t6_sweep_cen",  sram_cen,  0);
      chk("t6_sweep_gwen", sram_gwen, 0);
      chk("t6_sweep_wen",  sram_wen,  0);
      chk("t6_sweep_d",    sram_d,    0);
      chk("t6_sweep_rdy",  req_rdy,   0);
      busy_cnt++;
      @(posedge clk);
      #1;
    end
    chk("t6_busy_cycles", busy_cnt, 16);
    chk("t6_idle_pins_cen", sram_cen, 1);
    op_rd("t6_rd7", 4'h7);
    tick();
    req_vld = 1'b0;
    tick();
    chk("t6_rd7_vld", rsp_vld, 1);
    chk("t6_rd7_data", rsp_rdata, 0);
`endif

    // Test 1: full write, read back; rsp_vld two cycles after the read accept.
    op_wr("t1_wr", A1, {16{8'hA5}}, '1);
    op_rd("t1_rd", A1);
    tick();
    req_vld = 1'b0;
    #1;
    chk("t1_vld_lat1", rsp_vld, 0);
    chk_idle("t1_idle");
    tick();
    chk("t1_vld_lat2", rsp_vld, 1);
    chk("t1_data", rsp_rdata, {16{8'hA5}});
    tick();
    chk("t1_popped", rsp_vld, 0);

    // Test 2: masked writes, a zero-mask no-op, and read-after-write.
    op_wr("t2_clr",  A2, 128'h0, '1);
    op_wr("t2_lo",   A2, 128'hCDEF_0077, 128'hFF);
    op_wr("t2_nop",  A2, '1, '0);
    op_wr("t2_hi",   A2, 128'h1234, 128'hFF00);
    op_rd("t2_rd",   A2);
    tick();
    req_vld = 1'b0;
    tick();
    chk("t2_vld", rsp_vld, 1);
    chk("t2_data", rsp_rdata, 128'h1277);
    tick();

    // Test 3: rsp_rdy=0 with three reads; third waits for a pop, order kept.
    op_wr("t3_wr", A3, {16{8'hC3}}, '1);
    rsp_rdy = 1'b0;
    op_rd("t3_rd1", A1);
    op_rd("t3_rd2", A2);
    tick();
    req_vld = 1'b1; req_wr = 1'b0; req_addr = A3;
    #1;
    chk("t3_rd3_blocked", req_rdy, 0);
    chk("t3_rd3_cen", sram_cen, 1);
    tick();
    chk("t3_full_vld", rsp_vld, 1);
    chk("t3_head1", rsp_rdata, {16{8'hA5}});
    rsp_rdy = 1'b1;
    #1;
    chk("t3_pop_no_credit", req_rdy, 0);
    tick();
    rsp_rdy = 1'b0;
    #1;
    chk("t3_rd3_rdy", req_rdy, 1);
    chk("t3_rd3_a", sram_a, A3);
    chk("t3_head2", rsp_rdata, 128'h1277);
    tick();
    req_vld = 1'b0;
    #1;
    chk("t3_hold_vld", rsp_vld, 1);
    chk("t3_hold_data", rsp_rdata, 128'h1277);
    tick();
    rsp_rdy = 1'b1;
    #1;
    chk("t3_head2_again", rsp_rdata, 128'h1277);
    tick();
    chk("t3_head3", rsp_rdata, {16{8'hC3}});
    tick();
    chk("t3_empty", rsp_vld, 0);

    // Test 4: a read offered every cycle, FIFO filled then drained while still offered.
    for (int i = 0; i < 4; i++) begin
      a4 = AW'(8 + i);
      op_wr("t4_wr", a4, {4{32'hD00D_0000 + i}}, '1);
    end
    pops = 0; accepts = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      rsp_rdy = (n >= 4);
      req_vld = 1'b1; req_wr = 1'b0;
      a4 = AW'(8 + (n % 4));
      req_addr = a4;
      #1;
      if (n == 3) begin
        chk("t4_full_vld", rsp_vld, 1);
        chk("t4_full_rdy", req_rdy, 0);
      end
      if (rsp_vld && rsp_rdy) begin
        chk("t4_q_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("t4_order", rsp_rdata, exp_q.pop_front());
        pops++;
      end
      if (req_rdy) begin
        exp_q.push_back(exp_mem[a4]);
        accepts++;
      end
    end
    tick();
    req_vld = 1'b0;
    for (int n = 0; n < 10; n++) begin
      #1;
      if (rsp_vld && rsp_rdy) begin
        chk("t4_q_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("t4_drain", rsp_rdata, exp_q.pop_front());
        pops++;
      end
      tick();
    end
    chk("t4_all_returned", pops, accepts);
    chk("t4_q_left", exp_q.size(), 0);

    // Test 5: reset the cycle after a read accept drops the response.
    op_rd("t5_rd", A1);
    tick();
    req_vld = 1'b0;
    cpurst_b = 1'b0;
    #1;
    chk("t5_rst_vld", rsp_vld, 0);
    req_vld = 1'b1; req_wr = 1'b1; req_wmask = '1;
    #1;
    chk("t5_rst_rdy", req_rdy, 0);
    chk("t5_rst_cen", sram_cen, 1);
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("t5_rst_hold_vld", rsp_vld, 0);
    end
    req_vld = 1'b0;
    cpurst_b = 1'b1;
`ifdef CT_SPSRAM_INIT_EN
    busy_cnt = 0;
    for (int k = 0; k < 40 && init_busy; k++) begin
      busy_cnt++;
      tick();
    end
    chk("t5_resweep_cycles", busy_cnt, 16);
`endif
    for (int n = 0; n < 4; n++) begin
      #1;
      chk("t5_post_vld", rsp_vld, 0);
      chk_idle("t5_post_idle");
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
